wishbone_arbiter: RTL
=====================

# wishbone_arbiter

Round-robin arbiter and sequencer that shares one Wishbone classic master bus between N_REQ independent transaction requesters. Each requester posts a single read or write with a level request; the arbiter grants one at a time, drives the bus cycle, and handles ack, err, rty and a no-response timeout. It returns a one-cycle completion pulse with status and read data. It sits between the test-side transaction sources and the Wishbone master pins that feed the UART register interface.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, cycles without ack/err/rty before a forced termination (1..65535)
- MAX_RETRY, 3, rty responses tolerated per transaction before reporting error
- clk  in  1  bus clock; all logic on rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- req  in  N_REQ  per-requester request level
- we_in  in  N_REQ  per-requester direction (1 = write)
- adr_in  in  32*N_REQ  address; requester i at bits [32i+31:32i]
- dat_in  in  32*N_REQ  write data, same packing
- sel_in  in  4*N_REQ  byte selects; requester i at [4i+3:4i]
- gnt  out  N_REQ  one-hot; high for the granted requester for the whole transaction
- done  out  N_REQ  one-cycle completion pulse for the granted requester
- status_err  out  1  valid with any done bit; 1 = err, timeout or retry exhaustion
- rdata  out  32  read data; valid with done for a successful read
- adr, dout, sel, we, cyc, stb  out  32/32/4/1/1/1  Wishbone master outputs
- din  in  32  Wishbone read data
- ack, err, rty  in  1  Wishbone terminations

## Operation
- Reset values: gnt=0, done=0, status_err=0, rdata=0, adr=0, dout=0, sel=0, we=0, cyc=0, stb=0. Round-robin pointer set so requester 0 has top priority. Retry and timeout counters are 0. State is IDLE.
- IDLE:
  - If any req is high, choose the first requester at or after (last_grant+1) mod N_REQ.
  - Latch that requester's adr, dat, sel and we into the bus output registers.
  - Set its gnt bit, assert cyc and stb, clear the timeout counter, and go to BUS.
- BUS: cyc and stb are held high. Each cycle, terminations are evaluated in priority order err > ack > rty > timeout:
  - err: terminate with status_err=1.
  - ack: terminate with status_err=0. On a read, capture din into rdata.
  - rty with retry count < MAX_RETRY: increment the retry count and go to BACKOFF.
  - rty with retry count = MAX_RETRY: terminate with status_err=1.
  - No response: the timeout counter increments. When it reaches TIMEOUT, terminate with status_err=1.
- BACKOFF: cyc=stb=0 for exactly one cycle, with the latched fields held. Then go back to BUS with the timeout counter cleared.
- Terminate:
  - cyc and stb go low.
  - The granted requester's done bit pulses for one cycle, together with status_err and rdata.
  - gnt is cleared in the same cycle that done is high.
  - last_grant is updated to the granted index, the retry count is cleared, and the state returns to IDLE.
- rdata holds its value until the next successful read. status_err is meaningful only while a done bit is high and is 0 otherwise.
- Requester contract:
  - Hold req and all fields stable until done.
  - Dropping req mid-transaction does not abort it; the transaction completes and done still pulses.
  - A req still high in the cycle after done is treated as a new request.
- Only one bus transaction is ever outstanding; cyc and gnt are never high with gnt containing more than one bit.

## Timing
- req high before edge k in IDLE: gnt, cyc, stb and the bus fields are valid after edge k.
- Zero-wait slave that acks at the first BUS edge m=k+1: done pulses after edge k+1. cyc is high for exactly 1 cycle.
- In general, a termination sampled at edge m gives cyc=0 and done=1 after edge m. done falls after edge m+1.
- Every transaction is followed by at least one IDLE cycle, so back-to-back throughput is at most one transaction per 2 cycles.
- Timeout fires on the TIMEOUT-th consecutive cycle in BUS without a termination.
- Each rty adds 2 cycles: the rty cycle plus one BACKOFF cycle.
- Asynchronous reset mid-transaction clears cyc and stb immediately. No done is issued for the aborted transaction. After reset deasserts, the arbiter restarts in IDLE with requester 0 first.

## Test plan
- Single write: req[2]=1, adr=0x10, dat=0xA5, sel=0xF; slave acks on the first cycle -> cyc high 1 cycle, adr=0x10, dout=0xA5, we=1, done[2] pulse, status_err=0.
- Round-robin: req=4'b1111 held, every access acked in 1 cycle -> grant order 0,1,2,3,0. Exactly one IDLE cycle between grants, and gnt is always one-hot.
- Read with wait states: req[1] read at 0x04; slave acks after 3 wait cycles with din=0x1234_5678 -> cyc high 4 cycles, rdata=0x12345678 with done[1], status_err=0.
- Retry: rty on the first 3 attempts, ack on the 4th -> 3 one-cycle cyc drops, then done with status_err=0. With rty on 4 attempts -> done with status_err=1.
- Timeout and priority: no response with TIMEOUT=8 -> cyc drops after 8 BUS cycles, status_err=1. ack and err in the same cycle -> status_err=1.
- Reset mid-BUS: rst=0 asserted two cycles into an access -> cyc and stb are 0 within the same cycle, no done pulse. After release with req=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter that shares one Wishbone classic master port between
// N_REQ requesters. It runs one bus cycle at a time and handles ack, err,
// rty with a bounded retry count, and a no-response timeout.
module wishbone_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ-1:0]     i_we,
  input  logic [32*N_REQ-1:0]  i_adr,
  input  logic [32*N_REQ-1:0]  i_dat,
  input  logic [4*N_REQ-1:0]   i_sel,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [N_REQ-1:0]     o_done,
  output logic                 o_status_err,
  output logic [31:0]          o_rdata,
  output logic [31:0]          o_adr,
  output logic [31:0]          o_dout,
  output logic [3:0]           o_sel,
  output logic                 o_we,
  output logic                 o_cyc,
  output logic                 o_stb,
  input  logic [31:0]          i_din,
  input  logic                 i_ack,
  input  logic                 i_err,
  input  logic                 i_rty
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TOW  = $clog2(TIMEOUT + 1);
  localparam int RTW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  state_t             r_state, w_stateNext;
  logic [N_REQ-1:0]   r_gnt, w_gntNext;
  logic [N_REQ-1:0]   r_done, w_doneNext;
  logic               r_statusErr, w_statusErrNext;
  logic [31:0]        r_rdata, w_rdataNext;
  logic [31:0]        r_adr, w_adrNext;
  logic [31:0]        r_dout, w_doutNext;
  logic [3:0]         r_sel, w_selNext;
  logic               r_we, w_weNext;
  logic               r_cyc, w_cycNext;
  logic               r_stb, w_stbNext;
  logic [IDXW-1:0]    r_lastGrant, w_lastGrantNext;
  logic [IDXW-1:0]    r_idx, w_idxNext;
  logic [RTW-1:0]     r_retry, w_retryNext;
  logic [TOW-1:0]     r_timeout, w_timeoutNext;
  logic [IDXW-1:0]    w_pick;
  logic               w_found;
  logic               w_term;
  logic               w_termErr;

  // Round-robin search: first requesting index after the last grant
  always_comb begin
    w_pick  = r_lastGrant;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && i_req[IDXW'((int'(r_lastGrant) + k) % N_REQ)]) begin
        w_found = 1'b1;
        w_pick  = IDXW'((int'(r_lastGrant) + k) % N_REQ);
      end
    end
  end

  // Next-state and next-output logic for the grant/bus sequencer
  always_comb begin
    w_stateNext     = r_state;
    w_gntNext       = r_gnt;
    w_doneNext      = '0;
    w_statusErrNext = 1'b0;
    w_rdataNext     = r_rdata;
    w_adrNext       = r_adr;
    w_doutNext      = r_dout;
    w_selNext       = r_sel;
    w_weNext        = r_we;
    w_cycNext       = r_cyc;
    w_stbNext       = r_stb;
    w_lastGrantNext = r_lastGrant;
    w_idxNext       = r_idx;
    w_retryNext     = r_retry;
    w_timeoutNext   = r_timeout;
    w_term          = 1'b0;
    w_termErr       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_idxNext     = w_pick;
          w_adrNext     = i_adr[32*int'(w_pick) +: 32];
          w_doutNext    = i_dat[32*int'(w_pick) +: 32];
          w_selNext     = i_sel[4*int'(w_pick) +: 4];
          w_weNext      = i_we[w_pick];
          w_gntNext     = N_REQ'(1) << w_pick;
          w_cycNext     = 1'b1;
          w_stbNext     = 1'b1;
          w_timeoutNext = '0;
          w_stateNext   = BUS;
        end
      end
      BUS: begin
        if (i_err) begin
          w_term    = 1'b1;
          w_termErr = 1'b1;
        end else if (i_ack) begin
          w_term = 1'b1;
          if (!r_we) begin
            w_rdataNext = i_din;
          end
        end else if (i_rty) begin
          if (r_retry < RTW'(MAX_RETRY)) begin
            w_retryNext = r_retry + 1'b1;
            w_cycNext   = 1'b0;
            w_stbNext   = 1'b0;
            w_stateNext = BACKOFF;
          end else begin
            w_term    = 1'b1;
            w_termErr = 1'b1;
          end
        end else if (r_timeout == TOW'(TIMEOUT - 1)) begin
          w_term    = 1'b1;
          w_termErr = 1'b1;
        end else begin
          w_timeoutNext = r_timeout + 1'b1;
        end
      end
      BACKOFF: begin
        w_cycNext     = 1'b1;
        w_stbNext     = 1'b1;
        w_timeoutNext = '0;
        w_stateNext   = BUS;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (w_term) begin
      w_cycNext       = 1'b0;
      w_stbNext       = 1'b0;
      w_doneNext      = r_gnt;
      w_statusErrNext = w_termErr;
      w_gntNext       = '0;
      w_lastGrantNext = r_idx;
      w_retryNext     = '0;
      w_stateNext     = IDLE;
    end
  end

  // State and output registers; reset aborts any bus cycle immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_statusErr <= 1'b0;
      r_rdata     <= '0;
      r_adr       <= '0;
      r_dout      <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_lastGrant <= IDXW'(N_REQ - 1);
      r_idx       <= '0;
      r_retry     <= '0;
      r_timeout   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_gnt       <= w_gntNext;
      r_done      <= w_doneNext;
      r_statusErr <= w_statusErrNext;
      r_rdata     <= w_rdataNext;
      r_adr       <= w_adrNext;
      r_dout      <= w_doutNext;
      r_sel       <= w_selNext;
      r_we        <= w_weNext;
      r_cyc       <= w_cycNext;
      r_stb       <= w_stbNext;
      r_lastGrant <= w_lastGrantNext;
      r_idx       <= w_idxNext;
      r_retry     <= w_retryNext;
      r_timeout   <= w_timeoutNext;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_status_err = r_statusErr;
  assign o_rdata      = r_rdata;
  assign o_adr        = r_adr;
  assign o_dout       = r_dout;
  assign o_sel        = r_sel;
  assign o_we         = r_we;
  assign o_cyc        = r_cyc;
  assign o_stb        = r_stb;

endmodule
